// File: rtl/eth_status_counters.sv
// Ethernet status event counters: per-event saturating counters, sticky flags, snapshot bank, error irq.
// Latency: event -> counter/sticky 2 edges, sticky -> irq 1 edge, rd_en -> rd_data/rd_valid 1 edge.
// Backpressure: none; every input pulse is consumed each cycle and reads are accepted every cycle.
module eth_status_counters #(
    parameter int          NUM_EVENTS = 9,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [15:0] ERR_MASK   = 16'h00FA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          status_in,
    input  logic                 snap,
    input  logic                 clr,
    input  logic [15:0]          clr_mask,
    input  logic [15:0]          sticky_clr,
    input  logic                 rd_en,
    input  logic [3:0]           rd_addr,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic [15:0]          sticky,
    output logic                 irq
);

    // Bits at or above NUM_EVENTS have no counter and no sticky flag.
    localparam logic [15:0] EVT_MASK = 16'((32'd1 << NUM_EVENTS) - 32'd1);

    logic [15:0]          status_q;
    logic [CNT_WIDTH-1:0] cnt      [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] snap_cnt [NUM_EVENTS];
    logic [15:0]          clr_sel;
    logic [CNT_WIDTH-1:0] rd_mux;

    // Per-counter clear select, restricted to counters that exist.
    assign clr_sel = clr ? (clr_mask & EVT_MASK) : 16'h0000;

    // Register the incoming event pulses once; everything downstream counts from status_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_in;
        end
    end

    // Live counters: clear (keeping a same-cycle event as 1) beats increment; saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (clr_sel[i]) begin
                    cnt[i] <= CNT_WIDTH'(status_q[i]);
                end else if (status_q[i] && (cnt[i] != {CNT_WIDTH{1'b1}})) begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Snapshot bank: all counters captured on one edge with their pre-update values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                snap_cnt[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                snap_cnt[i] <= cnt[i];
            end
        end
    end

    // Sticky flags: set from status_q, write-one-to-clear; a same-cycle set wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= '0;
        end else begin
            sticky <= ((sticky & ~sticky_clr) | status_q) & EVT_MASK;
        end
    end

    // Error interrupt follows the masked sticky flags one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(sticky & ERR_MASK);
        end
    end

    // Read mux: counter addresses come from the snapshot bank, 4'hF is the live sticky word.
    always_comb begin
        rd_mux = '0;
        if (rd_addr == 4'hF) begin
            rd_mux = CNT_WIDTH'(sticky);
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (rd_addr == 4'(i)) begin
                    rd_mux = snap_cnt[i];
                end
            end
        end
    end

    // Read return register: one-cycle valid, data holds when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule
